// File: rtl/issue_select_n.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : issue_select_n
// Purpose  : Parametrised issue selector. Tracks N_ENTRY functional-unit
//            slots with up to N_SRC pending source tags each, wakes them
//            from the writeback broadcast, and offers the oldest ready slot
//            to execute through a valid/ready handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module issue_select_n #(
    parameter int N_ENTRY = 5,
    parameter int SLOT_W  = $clog2(N_ENTRY),
    parameter int N_SRC   = 3,
    parameter int TAG_W   = 5,
    parameter int AGE_W   = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   disp_valid,
    input  logic [SLOT_W-1:0]      disp_slot,
    input  logic [N_SRC-1:0]       disp_pend,
    input  logic [N_SRC*TAG_W-1:0] disp_tag,
    output logic                   disp_ready,
    input  logic                   wb_valid,
    input  logic [TAG_W-1:0]       wb_tag,
    output logic                   issue_valid,
    output logic [SLOT_W-1:0]      issue_slot,
    input  logic                   issue_ready,
    input  logic                   done_valid,
    input  logic [SLOT_W-1:0]      done_slot,
    input  logic                   flush,
    input  logic                   freeze,
    output logic [N_ENTRY-1:0]     slot_busy
);

    localparam logic [1:0]       S_EMPTY   = 2'd0;
    localparam logic [1:0]       S_WAIT    = 2'd1;
    localparam logic [1:0]       S_RDY     = 2'd2;
    localparam logic [1:0]       S_EX      = 2'd3;
    localparam logic [AGE_W-1:0] c_age_max = {AGE_W{1'b1}};

    // Per-slot decode of the index inputs; out-of-range indices match nothing.
    logic [N_ENTRY-1:0]  w_disp_hit;
    logic [N_ENTRY-1:0]  w_done_hit;
    logic [N_ENTRY-1:0]  w_empty;
    logic [N_ENTRY-1:0]  w_rdy;
    logic [AGE_W-1:0]    w_age [N_ENTRY];
    logic [N_SRC-1:0]    w_disp_pend_eff;
    logic                w_disp_fire;
    logic                w_issue_fire;
    logic                w_sel_found;
    logic [AGE_W-1:0]    w_sel_age;
    logic [SLOT_W-1:0]   w_sel_idx;

    // Same-cycle wakeup bypass: a source produced this cycle is not pending.
    for (genvar k = 0; k < N_SRC; k++) begin : g_disp_src
        assign w_disp_pend_eff[k] = disp_pend[k] &&
            !(wb_valid && (wb_tag == disp_tag[k*TAG_W +: TAG_W]));
    end

    assign disp_ready   = (|(w_disp_hit & w_empty)) && !flush;
    assign w_disp_fire  = disp_valid && disp_ready;
    assign slot_busy    = ~w_empty;

    // Oldest-first select; strict compare keeps the lowest index on ties.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_age   = '0;
        w_sel_idx   = '0;
        for (int i = 0; i < N_ENTRY; i++) begin
            if (w_rdy[i] && (!w_sel_found || (w_age[i] > w_sel_age))) begin
                w_sel_found = 1'b1;
                w_sel_age   = w_age[i];
                w_sel_idx   = SLOT_W'(i);
            end
        end
    end

    assign issue_valid  = w_sel_found && !freeze && !flush;
    assign issue_slot   = w_sel_idx;
    assign w_issue_fire = issue_valid && issue_ready;

    for (genvar i = 0; i < N_ENTRY; i++) begin : g_slot
        logic [1:0]             r_state;
        logic [N_SRC-1:0]       r_pend;
        logic [N_SRC*TAG_W-1:0] r_tag;
        logic [AGE_W-1:0]       r_age;
        logic [N_SRC-1:0]       w_wake;
        logic [N_SRC-1:0]       w_pend_left;
        logic [AGE_W-1:0]       w_age_next;

        for (genvar k = 0; k < N_SRC; k++) begin : g_wake
            assign w_wake[k] = wb_valid && (r_tag[k*TAG_W +: TAG_W] == wb_tag);
        end

        assign w_disp_hit[i] = (disp_slot == SLOT_W'(i));
        assign w_done_hit[i] = (done_slot == SLOT_W'(i));
        assign w_empty[i]    = (r_state == S_EMPTY);
        assign w_rdy[i]      = (r_state == S_RDY);
        assign w_age[i]      = r_age;
        assign w_pend_left   = r_pend & ~w_wake;
        // Age saturates at its maximum and holds while issue is frozen.
        assign w_age_next    = (freeze || (r_age == c_age_max)) ?
                               r_age : r_age + AGE_W'(1);

        // Slot lifecycle: dispatch, wakeup, issue, completion, flush.
        always_ff @(posedge CLK) begin
            if (RST || flush) begin
                r_state <= S_EMPTY;
                r_pend  <= '0;
                r_tag   <= '0;
                r_age   <= '0;
            end else begin
                case (r_state)
                    S_EMPTY: begin
                        if (w_disp_fire && w_disp_hit[i]) begin
                            r_pend  <= w_disp_pend_eff;
                            r_tag   <= disp_tag;
                            r_age   <= '0;
                            r_state <= (|w_disp_pend_eff) ? S_WAIT : S_RDY;
                        end
                    end
                    S_WAIT: begin
                        r_pend <= w_pend_left;
                        r_age  <= w_age_next;
                        if (w_pend_left == '0) begin
                            r_state <= S_RDY;
                        end
                    end
                    S_RDY: begin
                        if (w_issue_fire && (w_sel_idx == SLOT_W'(i))) begin
                            r_state <= S_EX;
                            r_age   <= '0;
                        end else begin
                            r_age <= w_age_next;
                        end
                    end
                    S_EX: begin
                        if (done_valid && w_done_hit[i]) begin
                            r_state <= S_EMPTY;
                        end
                    end
                    default: begin
                        r_state <= S_EMPTY;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
